// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_pkg
// Description : Shared definitions for the JK-cell up/down counter.
//               - 2-bit JK command encodings, packed as {J, K}
//               - modulus_ok(): legality check for the counter modulus
// Revision    : 1.0 - initial release
// ============================================================================
package jk_pkg;

    // {J, K} command applied to a single JK cell
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // A modulus is legal when 2 <= modulus <= 2**width. The arithmetic is
    // done in 64 bits so that wide counters cannot overflow the bound.
    function automatic bit modulus_ok(input int width, input int modulus);
        return (width >= 1) && (width <= 62) && (modulus >= 2) &&
               (longint'(modulus) <= (longint'(1) << width));
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_updown_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : jk_updown_counter_if
// Description : Control/status bundle of the JK up/down counter.
//               master : drives EN, UP, LOAD, D; observes the counter status
//               slave  : the counter; drives Q, Q_not, TC, WRAP, LOAD_ERR
//               With GRAY_OUT_EN defined the bundle also carries G, the
//               registered Gray-coded copy of Q.
// Revision    : 1.0 - initial release
// ============================================================================
interface jk_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             EN;
    logic             UP;
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_not;
    logic             TC;
    logic             WRAP;
    logic             LOAD_ERR;
`ifdef GRAY_OUT_EN
    logic [WIDTH-1:0] G;
`endif

`ifdef GRAY_OUT_EN
    modport master (output EN, UP, LOAD, D,
                    input  Q, Q_not, TC, WRAP, LOAD_ERR, G);
    modport slave  (input  EN, UP, LOAD, D,
                    output Q, Q_not, TC, WRAP, LOAD_ERR, G);
`else
    modport master (output EN, UP, LOAD, D,
                    input  Q, Q_not, TC, WRAP, LOAD_ERR);
    modport slave  (input  EN, UP, LOAD, D,
                    output Q, Q_not, TC, WRAP, LOAD_ERR);
`endif

endinterface
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ============================================================================
// Module      : jk_cell
// Description : Single-bit rising-edge JK flip-flop.
//               CLK   - clock
//               RST   - synchronous active-high reset, clears the cell to 0
//               J, K  - 00 hold, 01 clear, 10 set, 11 toggle
//               Q     - cell state
//               Q_not - complement of the cell state
// Revision    : 1.0 - initial release
// ============================================================================
module jk_cell (
    input  wire logic CLK,
    input  wire logic RST,
    input  wire logic J,
    input  wire logic K,
    output logic      Q,
    output logic      Q_not
);

    logic r_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q <= 1'b0;
        end else begin
            case ({J, K})
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign Q     = r_q;
    assign Q_not = ~r_q;

endmodule
`default_nettype wire

// File: rtl/jk_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : jk_updown_counter
// Description : Synchronous mod-MODULUS up/down counter built from WIDTH JK
//               cells. This block owns the per-bit J/K next-state logic; the
//               cell outputs are fed back into it.
//               CLK      - rising-edge clock
//               RST      - synchronous active-high reset
//               bus      - slave side of jk_updown_counter_if:
//                 EN/UP       count enable / direction (1 = up)
//                 LOAD/D      parallel load (out-of-range D clamps to MODULUS-1)
//                 Q/Q_not     count and its complement, straight from the cells
//                 TC          combinational terminal count
//                 WRAP        one-cycle pulse after a wrap
//                 LOAD_ERR    one-cycle pulse after an out-of-range load
//               Optional macro GRAY_OUT_EN adds registered output G = Gray(Q).
// Revision    : 1.0 - initial release
// ============================================================================
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    jk_updown_counter_if.slave   bus
);

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("jk_updown_counter: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the compare
    localparam logic [WIDTH:0]   c_mod = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_not;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_tc;
    logic             w_load_oor;
    logic [WIDTH-1:0] w_load_val;
    logic             w_force;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_toggle;
    logic [1:0]       w_jk [WIDTH];
    logic             r_wrap;
    logic             r_load_err;

    assign w_at_max   = (w_q == c_max);
    assign w_at_zero  = (w_q == '0);
    assign w_tc       = bus.EN & ((bus.UP & w_at_max) | (~bus.UP & w_at_zero));
    assign w_load_oor = ({1'b0, bus.D} >= c_mod);
    assign w_load_val = w_load_oor ? c_max : bus.D;

    // Two kinds of step: a forced step (load or wrap) drives every cell to
    // w_target, while an ordinary count only toggles the run of bits that a
    // binary +1/-1 would flip, i.e. q ^ (q +/- 1).
    always_comb begin
        w_force  = 1'b0;
        w_target = '0;
        w_toggle = '0;
        if (bus.LOAD) begin
            w_force  = 1'b1;
            w_target = w_load_val;
        end else if (bus.EN) begin
            if (w_tc) begin
                w_force  = 1'b1;
                w_target = bus.UP ? '0 : c_max;
            end else if (bus.UP) begin
                w_toggle = w_q ^ (w_q + WIDTH'(1));
            end else begin
                w_toggle = w_q ^ (w_q - WIDTH'(1));
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_jk[i] = w_force     ? (w_target[i] ? JK_SET : JK_RESET)
                       : w_toggle[i] ? JK_TOGGLE : JK_HOLD;

        jk_cell u_cell (
            .CLK   (CLK),
            .RST   (RST),
            .J     (w_jk[i][1]),
            .K     (w_jk[i][0]),
            .Q     (w_q[i]),
            .Q_not (w_q_not[i])
        );
    end

    // A wrap is the terminal-count step of an unloaded count
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= ~bus.LOAD & w_tc;
            r_load_err <= bus.LOAD & w_load_oor;
        end
    end

`ifdef GRAY_OUT_EN
    // Gray code of the value the cells take on this edge, so G and Q move
    // together.
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] r_g;

    assign w_q_next = w_force ? w_target : (w_q ^ w_toggle);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_g <= '0;
        end else begin
            r_g <= w_q_next ^ (w_q_next >> 1);
        end
    end

    assign bus.G = r_g;
`endif

    assign bus.Q        = w_q;
    assign bus.Q_not    = w_q_not;
    assign bus.TC       = w_tc;
    assign bus.WRAP     = r_wrap;
    assign bus.LOAD_ERR = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_jk_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_updown_counter
// Description : Self-checking bench for jk_updown_counter. Directed sequences
//               followed by random stimulus, all compared against a modular-
//               arithmetic reference model. With GRAY_OUT_EN defined the DUT
//               is built with MODULUS = 16 and G is checked as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_updown_counter;

    localparam int WIDTH = 4;
`ifdef GRAY_OUT_EN
    localparam int MODULUS = 16;
`else
    localparam int MODULUS = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    jk_updown_counter_if #(.WIDTH(WIDTH)) bus ();

    jk_updown_counter #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    int m_q     = 0;
    bit m_wrap  = 1'b0;
    bit m_lerr  = 1'b0;
    bit m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check TC before the edge and every
    // registered output after it.
    task automatic step(input bit s_rst, input bit s_en, input bit s_up,
                        input bit s_load, input int s_d);
        bit m_tc;
        rst      = s_rst;
        bus.EN   = s_en;
        bus.UP   = s_up;
        bus.LOAD = s_load;
        bus.D    = WIDTH'(s_d);
        #1;
        m_tc = s_en && ((s_up && m_q == MODULUS - 1) || (!s_up && m_q == 0));
        if (m_valid) check("tc", 32'(bus.TC), 32'(m_tc));

        @(posedge clk);
        if (s_rst) begin
            m_q = 0; m_wrap = 0; m_lerr = 0; m_valid = 1;
        end else if (m_valid) begin
            m_wrap = 0; m_lerr = 0;
            if (s_load) begin
                m_q    = (s_d < MODULUS) ? s_d : MODULUS - 1;
                m_lerr = (s_d >= MODULUS);
            end else if (s_en) begin
                if (s_up) begin
                    m_wrap = (m_q == MODULUS - 1);
                    m_q    = (m_q + 1) % MODULUS;
                end else begin
                    m_wrap = (m_q == 0);
                    m_q    = (m_q + MODULUS - 1) % MODULUS;
                end
            end
        end
        #1;
        if (m_valid) begin
            check("q",        32'(bus.Q),         32'(m_q));
            check("q_not",    32'(bus.Q_not),     32'((~m_q) & ((1 << WIDTH) - 1)));
            check("wrap",     32'(bus.WRAP),      32'(m_wrap));
            check("load_err", 32'(bus.LOAD_ERR),  32'(m_lerr));
`ifdef GRAY_OUT_EN
            check("gray",     32'(bus.G),         32'(m_q ^ (m_q >> 1)));
`endif
        end
    endtask

    initial begin
        bus.EN = 0; bus.UP = 0; bus.LOAD = 0; bus.D = '0;

        // Reset, then count up through a wrap
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);

        // Reset, then count down through the zero wrap
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Legal and out-of-range loads; LOAD_ERR must drop after one cycle
        step(0, 0, 0, 1, 6);
        step(0, 0, 0, 1, 13);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 15);
        step(0, 1, 1, 0, 0);

        // Priority: reset beats load and enable, load beats enable
        step(1, 1, 1, 1, 5);
        step(0, 1, 1, 1, 5);

        // Down to 4, hold three cycles, then alternate direction
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);

`ifdef GRAY_OUT_EN
        // Natural overflow is still flagged; spot values of the Gray output
        step(0, 0, 0, 1, 15);
        check("gray15", 32'(bus.G), 32'h8);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 3);
        check("gray3", 32'(bus.G), 32'h2);
`endif

        // Random stimulus
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, (1 << WIDTH) - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
